// File: rtl/step_debug_panel.sv
// Processor step/observe panel: debounced step key or auto-run clock enable, step counter,
// channel select and 7-segment display. Optional macro BLANK_LEADING_ZEROS_EN blanks leading-zero digits.
module step_debug_panel #(
   parameter  int DATA_W          = 16,
   parameter  int NUM_CH          = 4,
   parameter  int NUM_DIGITS      = 4,
   parameter  int DEBOUNCE_CYCLES = 16,
   parameter  int AUTO_DIV        = 8,
   localparam int CH_SEL_W        = $clog2(NUM_CH)
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         KeyStep_n,
   input  logic                         KeySel_n,
   input  logic                         AutoRun,
   input  logic [NUM_CH*DATA_W-1:0]     ChData,
   output logic                         StepEn,
   output logic [15:0]                  StepCount,
   output logic [CH_SEL_W-1:0]          ChSel,
   output logic [NUM_DIGITS*7-1:0]      HexOut
);
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DIV_W  = $clog2(AUTO_DIV);
   localparam int WIDE_W = (NUM_DIGITS * 4 > DATA_W) ? NUM_DIGITS * 4 : DATA_W;
   localparam logic [6:0] BLANK = 7'b1111111;
`ifdef BLANK_LEADING_ZEROS_EN
   localparam bit BLANK_LZ = 1'b1;
`else
   localparam bit BLANK_LZ = 1'b0;
`endif

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = BLANK;
      endcase
   endfunction

   // Index 0 is the step key, index 1 the select key.
   logic [1:0]            key_s1_q, key_s2_q, db_q, db_d, arm_q, arm_d, press_s, valid_q;
   logic [DB_W-1:0]       cnt_q [2];
   logic [DB_W-1:0]       cnt_d [2];
   logic                  auto_s1_q, auto_s2_q, auto_prev_q, auto_chg_s;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  step_q, step_d;
   logic [15:0]           count_q;
   logic [CH_SEL_W-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]     chan_s;
   logic [WIDE_W-1:0]     wide_s;
   logic [NUM_DIGITS*7-1:0] hex_q, hex_d;

   // A key is armed only after a genuine released sample, so a key held through reset is ignored.
   always_comb begin
      db_d    = db_q;
      arm_d   = arm_q;
      press_s = 2'b00;
      for (int k = 0; k < 2; k++) begin
         cnt_d[k] = cnt_q[k];
         arm_d[k] = arm_q[k] | (valid_q[1] & key_s2_q[k]);
         if (key_s2_q[k] != db_q[k]) begin
            if (cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_d[k]    = ~db_q[k];
               cnt_d[k]   = '0;
               press_s[k] = db_q[k] & arm_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + DB_W'(1);
            end
         end else begin
            cnt_d[k] = '0;
         end
      end
   end

   assign auto_chg_s = (auto_s2_q != auto_prev_q);

   always_comb begin
      div_d  = div_q;
      step_d = 1'b0;
      if (auto_chg_s) begin
         div_d = '0;
      end else if (auto_s2_q) begin
         step_d = (div_q == DIV_W'(AUTO_DIV - 1));
         div_d  = step_d ? '0 : div_q + DIV_W'(1);
      end else begin
         div_d  = '0;
         step_d = press_s[0];
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (press_s[1]) begin
         sel_d = (sel_q == CH_SEL_W'(NUM_CH - 1)) ? '0 : sel_q + CH_SEL_W'(1);
      end else begin
         sel_d = sel_q;
      end
   end

   // Digits past the channel width are blank; a partial top nibble is zero-extended.
   always_comb begin
      chan_s = ChData[0 +: DATA_W];
      for (int k = 0; k < NUM_CH; k++) begin
         chan_s = (sel_q == CH_SEL_W'(k)) ? ChData[k*DATA_W +: DATA_W] : chan_s;
      end
      wide_s = WIDE_W'(chan_s);
      hex_d  = {NUM_DIGITS{BLANK}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i * 4 >= DATA_W) begin
            hex_d[i*7 +: 7] = BLANK;
         end else if (BLANK_LZ && (i != 0) && ((wide_s >> (4 * i)) == '0)) begin
            hex_d[i*7 +: 7] = BLANK;
         end else begin
            hex_d[i*7 +: 7] = glyph(wide_s[i*4 +: 4]);
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         key_s1_q    <= 2'b11;
         key_s2_q    <= 2'b11;
         auto_s1_q   <= 1'b0;
         auto_s2_q   <= 1'b0;
         auto_prev_q <= 1'b0;
         valid_q     <= 2'b00;
         db_q        <= 2'b11;
         arm_q       <= 2'b00;
         cnt_q[0]    <= '0;
         cnt_q[1]    <= '0;
         div_q       <= '0;
         step_q      <= 1'b0;
         count_q     <= '0;
         sel_q       <= '0;
         hex_q       <= {NUM_DIGITS{BLANK}};
      end else begin
         key_s1_q    <= {KeySel_n, KeyStep_n};
         key_s2_q    <= key_s1_q;
         auto_s1_q   <= AutoRun;
         auto_s2_q   <= auto_s1_q;
         auto_prev_q <= auto_s2_q;
         valid_q     <= {valid_q[0], 1'b1};
         db_q        <= db_d;
         arm_q       <= arm_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         step_q      <= step_d;
         count_q     <= count_q + {15'd0, step_q};
         sel_q       <= sel_d;
         hex_q       <= hex_d;
      end
   end

   assign StepEn    = step_q;
   assign StepCount = count_q;
   assign ChSel     = sel_q;
   assign HexOut    = hex_q;
endmodule

// File: tb/tb_step_debug_panel.sv
// Randomized bench for step_debug_panel; outputs are checked against a cycle-level behavioural model.
module tb_step_debug_panel;
   localparam int DATA_W = 16, NUM_CH = 4, ND = 4, DB = 16, AD = 8, SW = 2;

   logic Clock = 1'b0;
   logic Reset, KeyStep_n, KeySel_n, AutoRun;
   logic [NUM_CH*DATA_W-1:0] ChData;
   logic StepEn;
   logic [15:0] StepCount;
   logic [SW-1:0] ChSel;
   logic [ND*7-1:0] HexOut;
   int checks = 0, failures = 0;

   always #5 Clock = ~Clock;

   step_debug_panel #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_DIGITS(ND),
                      .DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
      .Clock(Clock), .Reset(Reset), .KeyStep_n(KeyStep_n), .KeySel_n(KeySel_n),
      .AutoRun(AutoRun), .ChData(ChData), .StepEn(StepEn), .StepCount(StepCount),
      .ChSel(ChSel), .HexOut(HexOut));

   logic [6:0] glyph_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef BLANK_LEADING_ZEROS_EN
   localparam logic [ND*7-1:0] HEX_A3   = {7'h7F, 7'h7F, 7'b0001000, 7'b0110000};
   localparam logic [ND*7-1:0] HEX_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
`else
   localparam logic [ND*7-1:0] HEX_A3   = {7'b1000000, 7'b1000000, 7'b0001000, 7'b0110000};
   localparam logic [ND*7-1:0] HEX_ZERO = {4{7'b1000000}};
`endif

   // Reference model state: pin history, debounced levels, arming, auto phase, expected outputs.
   logic m_h1 [2], m_h2 [2];
   bit   m_g1 [2], m_g2 [2], m_arm [2];
   logic m_db [2];
   int   m_run [2];
   logic m_a1, m_a2, m_prev;
   int   m_phase, e_sel;
   logic e_step;
   logic [15:0] e_count;
   logic [ND*7-1:0] e_hex;

   function automatic logic [ND*7-1:0] exp_hex(input logic [DATA_W-1:0] v);
      logic [ND*7-1:0] r;
      longint unsigned rest;
      for (int i = 0; i < ND; i++) begin
         rest = longint'(v) >> (4 * i);
         if (i * 4 >= DATA_W) r[i*7 +: 7] = 7'h7F;
         else r[i*7 +: 7] = glyph_tbl[int'(rest & 64'd15)];
`ifdef BLANK_LEADING_ZEROS_EN
         if (i > 0 && rest == 0) r[i*7 +: 7] = 7'h7F;
`endif
      end
      return r;
   endfunction

   function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
      logic [NUM_CH*DATA_W-1:0] r;
      logic [DATA_W-1:0] v;
      for (int k = 0; k < NUM_CH; k++) begin
         v = DATA_W'($urandom);
         v = v >> (4 * $urandom_range(0, 4));
         r[k*DATA_W +: DATA_W] = v;
      end
      return r;
   endfunction

   task automatic model_edge();
      logic s, sa, old_step;
      bit gen;
      logic ev [2];
      logic raw [2];
      if (Reset) begin
         m_h1 = '{1'b1, 1'b1}; m_h2 = '{1'b1, 1'b1};
         m_g1 = '{0, 0}; m_g2 = '{0, 0}; m_arm = '{0, 0};
         m_db = '{1'b1, 1'b1}; m_run = '{0, 0};
         m_a1 = 1'b0; m_a2 = 1'b0; m_prev = 1'b0; m_phase = 0;
         e_step = 1'b0; e_count = 16'd0; e_sel = 0; e_hex = {ND{7'h7F}};
      end else begin
         old_step = e_step;
         raw[0] = KeyStep_n; raw[1] = KeySel_n;
         for (int k = 0; k < 2; k++) begin
            s = m_h2[k]; gen = m_g2[k];
            m_h2[k] = m_h1[k]; m_g2[k] = m_g1[k];
            m_h1[k] = raw[k];  m_g1[k] = 1;
            ev[k] = 1'b0;
            if (s !== m_db[k]) m_run[k]++; else m_run[k] = 0;
            if (m_run[k] == DB) begin
               m_db[k] = ~m_db[k];
               m_run[k] = 0;
               ev[k] = (m_db[k] == 1'b0) && m_arm[k];
            end
            if (gen && s === 1'b1) m_arm[k] = 1;
         end
         sa = m_a2; m_a2 = m_a1; m_a1 = AutoRun;
         if (sa !== m_prev) begin
            m_phase = 0; e_step = 1'b0;
         end else if (sa) begin
            e_step = (m_phase == AD - 1);
            m_phase = (m_phase + 1) % AD;
         end else begin
            m_phase = 0; e_step = ev[0];
         end
         m_prev = sa;
         e_count = e_count + {15'd0, old_step};
         e_hex = exp_hex(ChData[e_sel*DATA_W +: DATA_W]);
         if (ev[1]) e_sel = (e_sel + 1) % NUM_CH;
      end
   endtask

   initial forever begin
      @(posedge Clock);
      model_edge();
   end

   task automatic test_reset();
      Reset = 1'b1; KeyStep_n = 1'b1; KeySel_n = 1'b1; AutoRun = 1'b0;
      ChData = rand_data();
      ChData[DATA_W-1:0] = 16'h00A3;
      repeat (3) @(negedge Clock);
      checks++;
      if (StepEn !== 1'b0 || StepCount !== 16'd0 || ChSel !== 2'd0 || HexOut !== {ND{7'h7F}}) begin
         failures++;
         $display("FAIL reset_state got step=%b cnt=%0d sel=%0d hex=%h", StepEn, StepCount, ChSel, HexOut);
      end
      Reset = 1'b0;
      for (int j = 0; j < 50; j++) begin
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
      end
      checks++;
      if (HexOut !== HEX_A3 || StepCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_display got hex=%h cnt=%0d exp hex=%h cnt=0", HexOut, StepCount, HEX_A3);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0, pulse_at = -1;
      logic [15:0] c0 = e_count;
      for (int j = 0; j < 70; j++) begin
         KeyStep_n = (j < 30) ? (((j / 3) % 2) == 0 ? 1'b0 : 1'b1) : 1'b0;
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL bounce_model cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
         if (StepEn === 1'b1) begin pulses++; pulse_at = j - 29; end
      end
      checks++;
      if (pulses != 1 || pulse_at != DB + 2) begin
         failures++;
         $display("FAIL bounce_pulse got pulses=%0d at=%0d exp pulses=1 at=%0d", pulses, pulse_at, DB + 2);
      end
      checks++;
      if (StepCount !== c0 + 16'd1) begin
         failures++;
         $display("FAIL bounce_count got=%0d exp=%0d", StepCount, c0 + 16'd1);
      end
      KeyStep_n = 1'b1;
      repeat (25) @(negedge Clock);
   endtask

   task automatic test_autorun();
      int pulses = 0, prev = -1, post = 0;
      int st = $urandom_range(2, 5);
      AutoRun = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         KeyStep_n = (j >= st && j < st + 24) ? 1'b0 : 1'b1;
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL autorun_model cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
         if (StepEn === 1'b1) begin
            pulses++;
            if (prev >= 0) begin
               checks++;
               if (j - prev != AD) begin
                  failures++;
                  $display("FAIL autorun_period got=%0d exp=%0d", j - prev, AD);
               end
            end
            prev = j;
         end
      end
      checks++;
      if (pulses < 4 || pulses > 5) begin
         failures++;
         $display("FAIL autorun_pulses got=%0d exp=4..5", pulses);
      end
      AutoRun = 1'b0; KeyStep_n = 1'b1;
      for (int j = 0; j < 25; j++) begin
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL autorun_drop cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
         if (StepEn === 1'b1) post++;
      end
      checks++;
      if (post != 0) begin
         failures++;
         $display("FAIL autorun_extra got pulses=%0d exp=0", post);
      end
   endtask

   task automatic test_chsel();
      int seq [5] = '{1, 2, 3, 0, 1};
      int pulses;
      for (int p = 0; p < 5; p++) begin
         pulses = 0;
         for (int j = 0; j < 44; j++) begin
            KeySel_n  = (j < 22) ? 1'b0 : 1'b1;
            KeyStep_n = (p == 2 && j < 22) ? 1'b0 : 1'b1;
            ChData = rand_data();
            @(negedge Clock);
            checks++;
            if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
               failures++;
               $display("FAIL chsel_model p=%0d cyc=%0d got=%h exp=%h", p, j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
            end
            if (StepEn === 1'b1) pulses++;
         end
         checks++;
         if (ChSel !== SW'(seq[p]) || pulses != ((p == 2) ? 1 : 0)) begin
            failures++;
            $display("FAIL chsel_seq p=%0d got sel=%0d steps=%0d exp sel=%0d steps=%0d", p, ChSel, pulses, seq[p], (p == 2) ? 1 : 0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0, fresh = 0;
      for (int j = 0; j < 135; j++) begin
         Reset = (j >= 12 && j < 15);
         KeyStep_n = (j < 75 || j >= 105) ? 1'b0 : 1'b1;
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL resetmid_model cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
         if (StepEn === 1'b1) begin
            if (j < 105) pulses++; else fresh++;
         end
      end
      checks++;
      if (pulses != 0 || fresh != 1) begin
         failures++;
         $display("FAIL resetmid_events got held=%0d fresh=%0d exp held=0 fresh=1", pulses, fresh);
      end
      KeyStep_n = 1'b1;
      repeat (25) @(negedge Clock);
   endtask

   task automatic test_display();
      ChData = {NUM_CH{16'h0000}};
      @(negedge Clock);
      checks++;
      if (HexOut !== HEX_ZERO || HexOut !== e_hex) begin
         failures++;
         $display("FAIL display_zero got=%h exp=%h", HexOut, HEX_ZERO);
      end
      ChData = {NUM_CH{16'h00A3}};
      @(negedge Clock);
      checks++;
      if (HexOut !== HEX_A3 || HexOut !== e_hex) begin
         failures++;
         $display("FAIL display_a3 got=%h exp=%h", HexOut, HEX_A3);
      end
   endtask

   task automatic test_random();
      int kl = 1, sl = 1, al = 100;
      for (int j = 0; j < 3000; j++) begin
         kl = kl - 1; sl = sl - 1; al = al - 1;
         if (kl == 0) begin KeyStep_n = ~KeyStep_n; kl = $urandom_range(1, 40); end
         if (sl == 0) begin KeySel_n = ~KeySel_n; sl = $urandom_range(1, 40); end
         if (al == 0) begin AutoRun = ~AutoRun; al = $urandom_range(30, 300); end
         Reset = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 3) == 0) ChData = rand_data();
         @(negedge Clock);
         checks++;
         if ({StepEn, StepCount, ChSel, HexOut} !== {e_step, e_count, SW'(e_sel), e_hex}) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", j, {StepEn, StepCount, ChSel, HexOut}, {e_step, e_count, SW'(e_sel), e_hex});
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_autorun();
      test_chsel();
      test_reset_mid();
      test_display();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
